// File: rtl/axi_adder_master.sv
// AXI4-Lite master for the adder slave: writes operand A, writes operand B, reads the sum back.
// Latency: done rises 6 edges after start is accepted when the slave has zero wait states.
// Backpressure: each AXI valid is held until its own ready; start is ignored unless idle.
// Ports: start/operand_a/operand_b in; busy/done/result/status out; m0_axi_* AW/W/B/AR/R channels.
// Optional macro AXI_MASTER_TIMEOUT_EN: abort with SLVERR after TIMEOUT_CYCLES waiting on one handshake.
module axi_adder_master #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           ADDR_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] ADDR_OP_A      = 'h00,
   parameter logic [ADDR_WIDTH-1:0] ADDR_OP_B      = 'h04,
   parameter logic [ADDR_WIDTH-1:0] ADDR_RESULT    = 'h08,
   parameter int unsigned           TIMEOUT_CYCLES = 256
) (
   input  logic                    m0_axi_aclk,
   input  logic                    m0_axi_aresetn,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   operand_a,
   input  logic [DATA_WIDTH-1:0]   operand_b,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   result,
   output logic [1:0]              status,
   output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
   output logic                    m0_axi_awvalid,
   input  logic                    m0_axi_awready,
   output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
   output logic                    m0_axi_wvalid,
   input  logic                    m0_axi_wready,
   input  logic [1:0]              m0_axi_bresp,
   input  logic                    m0_axi_bvalid,
   output logic                    m0_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
   output logic                    m0_axi_arvalid,
   input  logic                    m0_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
   input  logic [1:0]              m0_axi_rresp,
   input  logic                    m0_axi_rvalid,
   output logic                    m0_axi_rready
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, WR_A, WB_A, WR_B, WB_B, RD, WR_R, DONE} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;

   logic                    busy_d, done_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
   logic [DATA_WIDTH-1:0]   result_d, wdata_d;
   logic [1:0]              status_d;
   logic [ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
   logic [STRB_W-1:0]       wstrb_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = m0_axi_awvalid & m0_axi_awready;
   assign w_hs  = m0_axi_wvalid  & m0_axi_wready;
   assign b_hs  = m0_axi_bready  & m0_axi_bvalid;
   assign ar_hs = m0_axi_arvalid & m0_axi_arready;
   assign r_hs  = m0_axi_rready  & m0_axi_rvalid;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge m0_axi_aclk or negedge m0_axi_aresetn) begin
      if (!m0_axi_aresetn) begin
         state_q        <= IDLE;
         op_b_q         <= '0;
         aw_done_q      <= 1'b0;
         w_done_q       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         result         <= '0;
         status         <= 2'b00;
         m0_axi_awaddr  <= '0;
         m0_axi_awvalid <= 1'b0;
         m0_axi_wdata   <= '0;
         m0_axi_wstrb   <= '0;
         m0_axi_wvalid  <= 1'b0;
         m0_axi_bready  <= 1'b0;
         m0_axi_araddr  <= '0;
         m0_axi_arvalid <= 1'b0;
         m0_axi_rready  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
         tmo_cnt_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         op_b_q         <= op_b_d;
         aw_done_q      <= aw_done_d;
         w_done_q       <= w_done_d;
         busy           <= busy_d;
         done           <= done_d;
         result         <= result_d;
         status         <= status_d;
         m0_axi_awaddr  <= awaddr_d;
         m0_axi_awvalid <= awvalid_d;
         m0_axi_wdata   <= wdata_d;
         m0_axi_wstrb   <= wstrb_d;
         m0_axi_wvalid  <= wvalid_d;
         m0_axi_bready  <= bready_d;
         m0_axi_araddr  <= araddr_d;
         m0_axi_arvalid <= arvalid_d;
         m0_axi_rready  <= rready_d;
`ifdef AXI_MASTER_TIMEOUT_EN
         tmo_cnt_q      <= tmo_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      op_b_d    = op_b_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      busy_d    = busy;
      done_d    = 1'b0;
      result_d  = result;
      status_d  = status;
      awaddr_d  = m0_axi_awaddr;
      awvalid_d = m0_axi_awvalid;
      wdata_d   = m0_axi_wdata;
      wstrb_d   = m0_axi_wstrb;
      wvalid_d  = m0_axi_wvalid;
      bready_d  = m0_axi_bready;
      araddr_d  = m0_axi_araddr;
      arvalid_d = m0_axi_arvalid;
      rready_d  = m0_axi_rready;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_b_d    = operand_b;
               busy_d    = 1'b1;
               awaddr_d  = ADDR_OP_A;
               wdata_d   = operand_a;
               wstrb_d   = '1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_A;
            end
         end
         WR_A, WR_B: begin
            // AW and W retire independently; either may finish first.
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               bready_d = 1'b1;
               state_d  = (state_q == WR_A) ? WB_A : WB_B;
            end
         end
         WB_A, WB_B: begin
            if (b_hs) begin
               bready_d = 1'b0;
               if (m0_axi_bresp != 2'b00) begin
                  // Failed write: abandon the remaining steps, result untouched.
                  status_d = m0_axi_bresp;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end else if (state_q == WB_A) begin
                  awaddr_d  = ADDR_OP_B;
                  wdata_d   = op_b_q;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = WR_B;
               end else begin
                  araddr_d  = ADDR_RESULT;
                  arvalid_d = 1'b1;
                  state_d   = RD;
               end
            end
         end
         RD: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = WR_R;
            end
         end
         WR_R: begin
            if (r_hs) begin
               // Read data is taken even on an error response.
               rready_d = 1'b0;
               result_d = m0_axi_rdata;
               status_d = m0_axi_rresp;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef AXI_MASTER_TIMEOUT_EN
      // Counter restarts whenever the state changes; it only runs while stuck.
      tmo_cnt_d = '0;
      if ((state_q inside {WR_A, WB_A, WR_B, WB_B, RD, WR_R}) && (state_d == state_q)) begin
         if (tmo_cnt_q == TMO_LAST) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            status_d  = 2'b10;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
`endif
   end

endmodule
